// File: rtl/conv_window_ctrl_b.sv
// conv_window_ctrl_b: raster IFM pixel stream -> convB 25-tap window FIFO shift control, window flag and OFM coordinates.
// Latency: fifo_enable/fifo_data_in are combinational with the accept; win_valid/out_row/out_col follow one cycle later.
// Backpressure: in_ready drops while a window is pending and win_ready is low, so the FIFO never shifts under a held window.
// Optional: define CONVB_WIN_COUNT_EN to add the win_count consumed-window counter port.
module conv_window_ctrl_b #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 28,
  parameter int KERNAL_SIZE = 5,
  parameter int OFM_SIZE    = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int CW          = $clog2(IFM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fifo_enable,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [CW-1:0]         out_row,
  output logic [CW-1:0]         out_col,
  output logic                  busy,
  output logic                  frame_done
`ifdef CONVB_WIN_COUNT_EN
  ,
  output logic [15:0]           win_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

  // Last pixel index on a row/column, and the row/column span whose taps form a full window.
  localparam logic [CW-1:0] LAST_IDX = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] WIN_LO   = CW'(KERNAL_SIZE - 1);
  localparam logic [CW-1:0] WIN_HI   = CW'(KERNAL_SIZE - 1 + OFM_SIZE - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] row, col;
  logic          accept, consume, last_pix, start_ok;

  assign accept       = in_valid && in_ready;
  assign consume      = win_valid && win_ready;
  assign last_pix     = (row == LAST_IDX) && (col == LAST_IDX);
  assign start_ok     = (state == IDLE) && start;
  assign fifo_enable  = accept;
  assign fifo_data_in = in_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the state-decoded handshake and status outputs.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = !win_valid || win_ready;
        if (in_valid && in_ready && last_pix) state_nxt = LAST;
      end
      LAST: begin
        if (consume) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position of the next pixel to accept; cleared when a frame starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (start_ok) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == LAST_IDX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window flag and OFM coordinate; a new accept wins over a consume so windows can issue back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (accept) begin
      // Columns below WIN_LO would straddle two IFM rows, so they never flag.
      win_valid <= (row >= WIN_LO) && (row <= WIN_HI) && (col >= WIN_LO) && (col <= WIN_HI);
      out_row   <= row - WIN_LO;
      out_col   <= col - WIN_LO;
    end else if (consume) begin
      win_valid <= 1'b0;
    end
  end

`ifdef CONVB_WIN_COUNT_EN
  // Consumed-window count; holds after frame_done until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         win_count <= '0;
    else if (start_ok) win_count <= '0;
    else if (consume)  win_count <= win_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl_b.sv
// tb_conv_window_ctrl_b: checks conv_window_ctrl_b against a pixel-index reference model of the window stream.
// Timing: inputs change 1ns after the rising edge, outputs are compared on the falling edge.
// Covers reset/idle, a streaming frame, backpressure hold, start while busy, mid-frame reset and a randomized frame.
`timescale 1ns/1ps
module tb_conv_window_ctrl_b;

  localparam int DW    = 32;
  localparam int IFM   = 28;
  localparam int K     = 5;
  localparam int OFM   = IFM - K + 1;
  localparam int CW    = $clog2(IFM);
  localparam int NPIX  = IFM * IFM;
  localparam int NWIN  = OFM * OFM;
  localparam int FIRST_WIN_PIX = (K - 1) * IFM + (K - 1) + 1;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_LAST = 2;
  localparam int PH_DONE = 3;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, win_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, fifo_enable, win_valid, busy, frame_done;
  logic [DW-1:0] fifo_data_in;
  logic [CW-1:0] out_row, out_col;
`ifdef CONVB_WIN_COUNT_EN
  logic [15:0]   win_count;
`endif

  conv_window_ctrl_b #(
    .DATA_WIDTH (DW),
    .IFM_SIZE   (IFM),
    .KERNAL_SIZE(K)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fifo_enable (fifo_enable),
    .fifo_data_in(fifo_data_in),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .out_row     (out_row),
    .out_col     (out_col),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef CONVB_WIN_COUNT_EN
    ,
    .win_count   (win_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame phase, pixels accepted so far, pending window and its coordinate.
  int m_ph, m_pix, m_orow, m_ocol, m_wc;
  bit m_wv;

  // DUT-observed frame bookkeeping.
  int n_acc, n_cons, n_done, last_r, last_c;
  bit seen_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs on the falling edge, advance the model, return 1ns after the rising edge.
  task automatic cycle();
    bit exp_rdy, acc, cons;
    int r, c;
    @(negedge clk);
    exp_rdy = (m_ph == PH_RUN) && (!m_wv || win_ready);
    chk("in_ready",     32'(in_ready),    32'(exp_rdy));
    chk("fifo_enable",  32'(fifo_enable), 32'(in_valid && exp_rdy));
    chk("fifo_data_in", fifo_data_in,     in_data);
    chk("win_valid",    32'(win_valid),   32'(m_wv));
    if (m_wv) begin
      chk("out_row", 32'(out_row), m_orow);
      chk("out_col", 32'(out_col), m_ocol);
    end
    chk("busy",       32'(busy),       32'(m_ph != PH_IDLE));
    chk("frame_done", 32'(frame_done), 32'(m_ph == PH_DONE));
`ifdef CONVB_WIN_COUNT_EN
    chk("win_count", 32'(win_count), m_wc);
`endif
    if (win_valid && !seen_win) begin
      seen_win = 1'b1;
      chk("first_win_after_pixels", n_acc, FIRST_WIN_PIX);
      chk("first_win_row", 32'(out_row), 0);
      chk("first_win_col", 32'(out_col), 0);
    end
    if (fifo_enable) n_acc++;
    if (win_valid && win_ready) begin
      chk("raster_row", 32'(out_row), n_cons / OFM);
      chk("raster_col", 32'(out_col), n_cons % OFM);
      last_r = int'(out_row);
      last_c = int'(out_col);
      n_cons++;
    end
    if (frame_done) n_done++;

    acc  = in_valid && exp_rdy;
    cons = m_wv && win_ready;
    case (m_ph)
      PH_IDLE: if (start) begin m_ph = PH_RUN; m_pix = 0; m_wc = 0; end
      PH_RUN:  if (acc && m_pix == NPIX - 1) m_ph = PH_LAST;
      PH_LAST: if (cons) m_ph = PH_DONE;
      default: m_ph = PH_IDLE;
    endcase
    if (cons) m_wc++;
    if (acc) begin
      r = m_pix / IFM;
      c = m_pix % IFM;
      m_wv = (r >= K - 1) && (c >= K - 1);
      if (m_wv) begin
        m_orow = r - (K - 1);
        m_ocol = c - (K - 1);
      end
      m_pix++;
    end else if (cons) begin
      m_wv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_win_valid",   32'(win_valid),   0);
    chk("rst_out_row",     32'(out_row),     0);
    chk("rst_out_col",     32'(out_col),     0);
    chk("rst_busy",        32'(busy),        0);
    chk("rst_frame_done",  32'(frame_done),  0);
    chk("rst_in_ready",    32'(in_ready),    0);
    chk("rst_fifo_enable", 32'(fifo_enable), 0);
`ifdef CONVB_WIN_COUNT_EN
    chk("rst_win_count",   32'(win_count),   0);
`endif
    m_ph = PH_IDLE; m_wv = 1'b0; m_wc = 0; m_orow = 0; m_ocol = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive(input bit rnd);
    in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    win_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    in_data   = rnd ? $urandom : m_pix;
  endtask

  task automatic begin_frame();
    n_acc = 0; n_cons = 0; n_done = 0; seen_win = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd);
    int k = 0;
    while (m_ph != PH_IDLE && k < 20000) begin
      drive(rnd);
      cycle();
      k++;
    end
    chk("frame_end_busy", 32'(busy),  0);
    chk("frame_windows",  n_cons,     NWIN);
    chk("frame_last_row", last_r,     OFM - 1);
    chk("frame_last_col", last_c,     OFM - 1);
    chk("frame_done_cnt", n_done,     1);
  endtask

  task automatic run_until_pix(input int n);
    int k = 0;
    while (m_pix < n && k < 20000) begin
      drive(1'b1);
      cycle();
      k++;
    end
    chk("pixel_target_reached", 32'(n_acc >= n), 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_data = '0;
    m_ph = PH_IDLE; m_pix = 0; m_orow = 0; m_ocol = 0; m_wc = 0; m_wv = 1'b0;
    n_acc = 0; n_cons = 0; n_done = 0; last_r = 0; last_c = 0; seen_win = 1'b0;
    #1;
    apply_reset();

    // Idle with a valid pixel offered: nothing may be accepted.
    in_valid = 1'b1; win_ready = 1'b1; in_data = 32'h1234_5678;
    repeat (4) cycle();
    chk("idle_no_accepts", n_acc, 0);

    // Frame 1: pixels 0..NPIX-1 every cycle, win_ready tied high.
    begin_frame();
    run_frame(1'b0);
    cycle();
    chk("f1_busy_after", 32'(busy), 0);
`ifdef CONVB_WIN_COUNT_EN
    chk("f1_win_count_hold", 32'(win_count), NWIN);
`endif

    // Frame 2: backpressure on window (0,0), start while busy, then reset mid-frame.
    in_valid = 1'b0;
    begin_frame();
`ifdef CONVB_WIN_COUNT_EN
    chk("f2_win_count_cleared", 32'(win_count), 0);
`endif
    begin
      int k = 0;
      in_valid = 1'b1; win_ready = 1'b1;
      while (!m_wv && k < 2000) begin
        in_data = $urandom;
        cycle();
        k++;
      end
    end
    chk("bp_window_pending", 32'(win_valid), 1);
    win_ready = 1'b0;
    repeat (3) begin
      in_data = $urandom;
      cycle();
      chk("bp_hold_row", 32'(out_row), 0);
      chk("bp_hold_col", 32'(out_col), 0);
    end
    chk("bp_no_accepts", n_acc, FIRST_WIN_PIX);
    win_ready = 1'b1;
    cycle();
    chk("bp_release_accept", n_acc, FIRST_WIN_PIX + 1);
    chk("bp_release_consume", n_cons, 1);

    run_until_pix(300);
    drive(1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until_pix(400);
    apply_reset();
    in_valid = 1'b1;
    repeat (3) cycle();
    chk("abort_no_frame_done", n_done, 0);

    // Frame 3: fresh start from (0,0) with randomized valid/ready.
    begin_frame();
    run_frame(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl_b.md
Name: conv_window_ctrl_b

Overview:
- Control stage directly upstream of the convB 25-tap sliding-window shift FIFO.
- Accepts a raster-order IFM pixel stream, drives the FIFO shift enable and data, and tracks the row/column of each pixel.
- Flags the cycles on which the FIFO's 25 taps hold a legal KxK window, and stalls the stream while a window is unconsumed.
- Reports the output-map coordinate of each window and a frame-done pulse.

Parameters:
- DATA_WIDTH, 32: pixel word width.
- IFM_SIZE, 28: input feature map width and height, in pixels.
- KERNAL_SIZE, 5: kernel width and height.
- OFM_SIZE, IFM_SIZE-KERNAL_SIZE+1: output map width and height (24 by default).
- CW, $clog2(IFM_SIZE): width of the row/column counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame. Ignored unless the FSM is in IDLE.
- in_valid  in  1  upstream pixel valid.
- in_data  in  DATA_WIDTH  upstream pixel.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- fifo_enable  out  1  shift strobe to the window FIFO.
- fifo_data_in  out  DATA_WIDTH  pixel to the window FIFO.
- win_valid  out  1  FIFO taps currently form a valid window.
- win_ready  in  1  downstream MAC consumes the window.
- out_row  out  CW  output-map row of the current window.
- out_col  out  CW  output-map column of the current window.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last window is consumed.

Behaviour:
- Reset (asynchronous): all of the following clear to 0.
  - State goes to IDLE.
  - row, col, out_row, out_col clear.
  - win_valid, busy, frame_done clear.
  - The window counter clears when present.
- FSM states: IDLE, RUN, LAST, DONE.
  - IDLE -> RUN on start. row and col clear on this transition.
  - RUN -> LAST when pixel (IFM_SIZE-1, IFM_SIZE-1) is accepted.
  - LAST -> DONE when win_valid && win_ready.
  - DONE -> IDLE unconditionally. frame_done = 1 only in DONE.
- Input handshake:
  - in_ready = (state==RUN) && (!win_valid || win_ready). This is combinational.
  - accept = in_valid && in_ready.
  - fifo_enable = accept, driven combinationally in the same cycle.
  - fifo_data_in = in_data, passed straight through.
  - The FIFO therefore never shifts while an unconsumed window is pending.
- Position tracking: (row, col) is the position of the next pixel to be accepted.
  - On accept, col increments.
  - When col == IFM_SIZE-1, col wraps to 0 and row increments.
- Window valid flag (registered; 1-cycle latency after the accept):
  - On accept of pixel (r, c), win_valid <= (r >= KERNAL_SIZE-1) && (c >= KERNAL_SIZE-1).
  - In the same update, out_row <= r-(KERNAL_SIZE-1) and out_col <= c-(KERNAL_SIZE-1).
  - Else, if win_valid && win_ready, win_valid <= 0.
  - Else, win_valid holds.
  - Simultaneous consume and accept: the accept update wins, so a valid window can be issued back-to-back every cycle.
- Row wrap-around: windows whose column span would straddle two IFM rows (c < KERNAL_SIZE-1) are never flagged.
- Count: exactly OFM_SIZE*OFM_SIZE windows per frame (576 by default), in raster order of (out_row, out_col).
- out_row and out_col hold their value while win_valid is held.
- The final pixel always produces a valid window, so the LAST state is always exited via win_ready.
- start while busy: ignored, with no effect on counters.
- Reset mid-frame: aborts the frame with no frame_done. The FIFO contents are not cleared by this block; the FIFO shares the same reset.

Optional Feature:
- Macro: CONVB_WIN_COUNT_EN.
- Defined:
  - Adds output win_count [15:0], which increments on every win_valid && win_ready.
  - win_count clears on reset and on an accepted start.
  - win_count holds its value after frame_done, so it equals 576 at the end of a default frame.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset and idle: hold reset, then release with no start → all outputs 0, in_ready=0, and in_valid=1 causes no fifo_enable.
- Full frame with win_ready tied high:
  - Stimulus: start, then 784 pixels with values 0..783 streamed every cycle.
  - Required: first win_valid appears the cycle after pixel 116 (row 4, col 4) with out_row=0, out_col=0.
  - Required: the last window is (23, 23).
  - Required: exactly 576 windows, frame_done one cycle after the final consume, busy=0 afterwards.
- Row wrap: during row 5, the pixels at col 0..3 → win_valid=0 the cycle after each; the pixel at col 4 → window (1, 0).
- Backpressure:
  - Stimulus: hold win_ready=0 for 3 cycles on window (0, 0).
  - Required: in_ready=0, fifo_enable=0, and win_valid, out_row, out_col stable during the hold.
  - Required: on release, the window is consumed and the next pixel is accepted in the same cycle.
- Start while busy and mid-frame reset:
  - Stimulus: pulse start at pixel 300 → no change to row/col.
  - Stimulus: assert reset at pixel 400 → all outputs 0 immediately, no frame_done; a subsequent start begins a fresh frame from (0, 0).
- CONVB_WIN_COUNT_EN: run a full frame, then start again → win_count reads 576 after the first frame and reads 0 the cycle after the accepted start.
